muldiv: RTL

Iterative multiply/divide unit that owns the HI/LO register pair of the MIPS core. It sits beside the single-cycle `alu` in EX. EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to it through a start/busy handshake. Results appear in `hi`/`lo` a fixed 33 cycles after a multiply or divide is accepted. The pipeline stalls MFHI/MFLO while `busy` is high.

---
 rtl/MIPS_DEF.sv | 13 +
 rtl/muldiv.sv | 126 ++++++++++++
 2 files changed

// File: rtl/MIPS_DEF.sv
// Core-wide definitions shared by the MIPS EX-stage units.
package MIPS_DEF;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIV  = 2'd1,
    MD_MTHI = 2'd2,
    MD_MTLO = 2'd3
  } mdop_t;

  localparam int MD_STEPS = 32;

endpackage

// File: rtl/muldiv.sv
// Iterative multiply/divide unit owning HI/LO: one radix-2 step per cycle,
// shift-add multiply and restoring divide over a shared 64-bit work register.
module muldiv
  import MIPS_DEF::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  mdop_t            op,
  input  logic             sign,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] work;      // MUL: {acc, multiplier}; DIV: {rem, dividend/quotient}
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_lo;    // product sign (MUL) or quotient sign (DIV)
  logic               neg_hi;    // remainder sign, DIV only
  logic               dz;        // divide by zero

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     madd;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] work_step;
  logic [2*WIDTH-1:0] work_neg;
  logic [WIDTH-1:0]   rem_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign busy = (state != S_IDLE);

  always_comb begin
    a_mag = (sign && a[WIDTH-1]) ? -a : a;
    b_mag = (sign && b[WIDTH-1]) ? -b : b;

    madd = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // Shifted partial remainder is 33 bits; when it is >= divisor the
    // difference fits in 32, so only the low half needs subtracting.
    ge   = work[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
    diff = work[2*WIDTH-2:WIDTH-1] - opnd;

    if (is_div)
      work_step = ge ? {diff, work[WIDTH-2:0], 1'b1} : {work[2*WIDTH-2:0], 1'b0};
    else
      work_step = work[0] ? {madd, work[WIDTH-1:1]} : {1'b0, work[2*WIDTH-1:1]};

    // Low half of the 64-bit negation doubles as the 32-bit quotient negation.
    work_neg = -work;
    rem_neg  = -work[2*WIDTH-1:WIDTH];

    fix_lo = neg_lo ? work_neg[WIDTH-1:0] : work[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_hi ? rem_neg : work[2*WIDTH-1:WIDTH];
      if (dz) fix_lo = '1;
    end else begin
      fix_hi = neg_lo ? work_neg[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      work   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            case (op)
              MD_MUL, MD_DIV: begin
                work   <= {{WIDTH{1'b0}}, a_mag};
                opnd   <= b_mag;
                is_div <= (op == MD_DIV);
                neg_lo <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_hi <= sign && a[WIDTH-1] && (op == MD_DIV);
                dz     <= (op == MD_DIV) && (b == '0);
                cnt    <= '0;
                state  <= S_CALC;
              end
              MD_MTHI: hi <= a;
              default: lo <= a;
            endcase
          end
          S_CALC: begin
            work <= work_step;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'(MD_STEPS - 1)) state <= S_FIX;
          end
          S_FIX: begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
